// File: rtl/data_cache_pkg.sv
// Shared types and constants for the L1 data cache and its byte-lane helper.
package data_cache_pkg;

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned MEM_ADDR_W = 28;
  localparam int unsigned WORD_W     = 32;

  typedef logic [1:0] cache_state_t;

  localparam cache_state_t IDLE      = 2'd0;
  localparam cache_state_t WRITEBACK = 2'd1;
  localparam cache_state_t FETCH     = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dcache_byte_lane.sv
// Combinational load extraction/extension and store lane merge for one 128-bit line.
module dcache_byte_lane
  import data_cache_pkg::*;
(
  input  logic [BLOCK_W-1:0] line_i,
  input  logic [3:0]         offset_i,
  input  logic [2:0]         funct3_i,
  input  logic [WORD_W-1:0]  wdata_i,
  output logic [WORD_W-1:0]  load_data_o,
  output logic [BLOCK_W-1:0] merged_line_o
);

  logic [6:0]  b_base;
  logic [6:0]  h_base;
  logic [6:0]  w_base;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Halfword and word bases drop the misaligned low offset bits.
  assign b_base   = {offset_i, 3'b000};
  assign h_base   = {offset_i[3:1], 4'b0000};
  assign w_base   = {offset_i[3:2], 5'b00000};
  assign byte_sel = line_i[b_base +: 8];
  assign half_sel = line_i[h_base +: 16];
  assign word_sel = line_i[w_base +: 32];

  always_comb begin
    load_data_o = word_sel;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'h000000, byte_sel};
      F3_HU:   load_data_o = {16'h0000, half_sel};
      F3_W:    load_data_o = word_sel;
      default: load_data_o = word_sel;
    endcase
  end

  // Store size comes from the low two funct3 bits; the sign bit is irrelevant for stores.
  always_comb begin
    merged_line_o = line_i;
    case (funct3_i[1:0])
      2'b00:   merged_line_o[b_base +: 8]  = wdata_i[7:0];
      2'b01:   merged_line_o[h_base +: 16] = wdata_i[15:0];
      default: merged_line_o[w_base +: 32] = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage
// and the block-wide data memory.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [2:0]            FUNCT3,
  input  logic [31:0]           ADDRESS,
  input  logic [31:0]           WRITEDATA,
  output logic [31:0]           READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam int unsigned INDEX_W = $clog2(NUM_SETS);
  localparam int unsigned OFF_W   = $clog2(BLOCK_BYTES);
  localparam int unsigned TAG_W   = 32 - OFF_W - INDEX_W;

  logic [3:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  cache_state_t       state_q, state_d;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]   tag_q  [NUM_SETS];
  logic [BLOCK_W-1:0] data_q [NUM_SETS];

  // Miss context is latched so the refill completes even if the request drops.
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;

  logic               req_c;
  logic               hit_c;
  logic               fill_c;
  logic               store_hit_c;
  logic [BLOCK_W-1:0] line_c;
  logic [BLOCK_W-1:0] merged_c;
  logic [31:0]        load_c;

  assign offset = ADDRESS[3:0];
  assign index  = ADDRESS[OFF_W +: INDEX_W];
  assign tag    = ADDRESS[31 -: TAG_W];
  assign line_c = data_q[index];

  assign req_c       = READ | WRITE;
  assign hit_c       = (state_q == IDLE) && valid_q[index] && (tag_q[index] == tag);
  assign store_hit_c = WRITE && hit_c;
  assign BUSYWAIT    = req_c && !hit_c;
  assign READDATA    = hit_c ? load_c : 32'h0;

  dcache_byte_lane u_lane (
    .line_i        (line_c),
    .offset_i      (offset),
    .funct3_i      (FUNCT3),
    .wdata_i       (WRITEDATA),
    .load_data_o   (load_c),
    .merged_line_o (merged_c)
  );

  // Next-state and memory-side request logic.
  always_comb begin
    state_d       = state_q;
    miss_tag_d    = miss_tag_q;
    miss_idx_d    = miss_idx_q;
    fill_c        = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      IDLE: begin
        if (req_c && !hit_c) begin
          miss_tag_d = tag;
          miss_idx_d = index;
          state_d    = (valid_q[index] && dirty_q[index]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = MEM_ADDR_W'({tag_q[miss_idx_q], miss_idx_q});
        MEM_WRITEDATA = data_q[miss_idx_q];
        if (!MEM_BUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = MEM_ADDR_W'({miss_tag_q, miss_idx_q});
        if (!MEM_BUSYWAIT) begin
          fill_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      if (fill_c) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end else if (store_hit_c) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Line storage carries no reset; validity alone qualifies its contents.
  always_ff @(posedge CLK) begin
    if (fill_c) begin
      data_q[miss_idx_q] <= MEM_READDATA;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (store_hit_c) begin
      data_q[index] <= merged_c;
    end
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the RV32IM MEM stage and the 128-bit block-wide data memory.
- Services byte, halfword and word loads and stores from the CPU side.
- Stalls the pipeline via BUSYWAIT on a miss.
- Drives block refills and dirty write-backs on the memory side using a READ/WRITE/BUSYWAIT handshake with a 28-bit block address.

Parameters:
- NUM_SETS, 8, number of cache lines; power of 2; INDEX_W = log2(NUM_SETS).
- BLOCK_BYTES, 16, bytes per line. Fixed by the memory block width; not to be overridden.

Ports:
CLK  in  1  clock, posedge
RESET  in  1  asynchronous, active-high reset
READ  in  1  CPU load request
WRITE  in  1  CPU store request
FUNCT3  in  3  RV32 access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ADDRESS  in  32  CPU byte address
WRITEDATA  in  32  CPU store data (low bits used for B/H)
READDATA  out  32  load result, extended per FUNCT3
BUSYWAIT  out  1  CPU stall
MEM_READ  out  1  block read request to memory
MEM_WRITE  out  1  block write request to memory
MEM_ADDRESS  out  28  block address (byte address >> 4)
MEM_WRITEDATA  out  128  block to write back
MEM_READDATA  in  128  block from memory
MEM_BUSYWAIT  in  1  memory busy; low = request completes this edge

Behaviour:
- Address split: offset = ADDRESS[3:0], index = ADDRESS[4+INDEX_W-1:4], tag = ADDRESS[31:4+INDEX_W].
- Per line state: valid, dirty, tag and 128-bit data. Byte k of the line is data[8k+7:8k], matching the memory byte order.
- Hit is combinational: valid[index] && tag match, evaluated only in IDLE.
- BUSYWAIT is combinational: (READ|WRITE) && !(state==IDLE && hit). It is low when no request is present.
- Read hit:
  - READDATA is valid combinationally in the same cycle with zero stall.
  - B/H select the byte or halfword at the offset. Halfwords use offset[3:1]; words use offset[3:2]; misaligned low bits are ignored.
  - 000/001 sign-extend; 100/101 zero-extend.
- Write hit:
  - On the posedge, the selected byte/half/word lanes are merged into the line and dirty is set.
  - No stall.
- State machine, states IDLE, WRITEBACK, FETCH:
  - IDLE, miss with line clean or invalid -> FETCH.
  - IDLE, miss with line valid and dirty -> WRITEBACK.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=line data. At the edge where MEM_BUSYWAIT=0 -> FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS={request tag, index}. At the edge where MEM_BUSYWAIT=0, the line is loaded from MEM_READDATA with valid=1, dirty=0, tag updated -> IDLE.
  - Back in IDLE the access now hits. A store then merges and sets dirty in that cycle.
- MEM_READ and MEM_WRITE are never both high. Both are 0 in IDLE.
- The request must stay stable while BUSYWAIT=1 (pipeline stalled). If the request drops mid-miss, the refill still completes.
- READ and WRITE both high is illegal; the cache treats it as WRITE.
- Reset (asynchronous, any state):
  - state=IDLE; all valid and dirty bits cleared.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - READDATA=0 when no hit; line data need not be cleared.
  - An in-flight write-back is abandoned; dirty data is lost by design.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: memory latency + 1 cycle.
  - Dirty miss: two memory latencies + 1 cycle.

Decomposition:
- Shared package:
  - cache_state_t (IDLE/WRITEBACK/FETCH).
  - FUNCT3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - BLOCK_W=128 and MEM_ADDR_W=28.
- Sub-module dcache_byte_lane (combinational): load extraction/extension and store lane merge from (line, offset, funct3, wdata). Shared with the instruction path later.

Test Plan:
1. Reset, then LW 0x0000_0040 with memory block 0x4 = bytes 0x00..0x0F -> FETCH; MEM_READ=1, MEM_ADDRESS=0x0000004; on completion READDATA=0x03020100 and BUSYWAIT falls.
2. After test 1, LB 0x43 and LBU 0x4F (memory byte 0x4F set to 0x8F) -> 0x00000003 and 0x0000008F with no stall; LB 0x4F returns 0xFFFFFF8F.
3. SH 0x46 data 0xBEEF (hit) -> no stall, dirty set; LHU 0x46 returns 0x0000BEEF; LH 0x46 returns 0xFFFFBEEF.
4. LW 0x0000_00C0 (same index 4, new tag) after test 3 -> WRITEBACK with MEM_ADDRESS=0x0000004, MEM_WRITEDATA bytes 6..7 = EF,BE; then FETCH with MEM_ADDRESS=0x000000C.
5. Assert RESET during FETCH -> MEM_READ drops immediately and BUSYWAIT=0; the same LW afterwards misses again (valid cleared).
6. Back-to-back SW hits to 0x40 and 0x44 -> both merged on consecutive edges; no MEM_* activity.
